// File: rtl/alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Sequential ALU. A START in IDLE captures A, B and OP. Single-cycle
//            ops (ADD/SUB/AND/OR/XOR/INC/DEC) finish in EXEC on the next edge.
//            MUL runs an unsigned shift-add over WIDTH edges. All outputs are
//            registered and hold until the next completion.
// Ports    : CLK        - clock, rising edge active
//            CLR_N      - asynchronous active-low reset
//            START      - operation request, sampled only in IDLE
//            OP[2:0]    - ADD,SUB,AND,OR,XOR,INC,DEC,MUL (000..111)
//            A, B       - operands, WIDTH bits
//            RESULT     - low result word
//            RESULT_HI  - high product word for MUL, 0 otherwise
//            FLAG_C/Z/V/N - carry, zero, signed overflow, negative
//            BUSY       - operation in progress
//            DONE       - one-cycle pulse, new results valid
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             FLAG_C,
    output logic             FLAG_Z,
    output logic             FLAG_V,
    output logic             FLAG_N,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_EXEC = 2'd1;
    localparam logic [1:0] C_ST_MUL  = 2'd2;

    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_AND = 3'b010;
    localparam logic [2:0] C_OP_OR  = 3'b011;
    localparam logic [2:0] C_OP_XOR = 3'b100;
    localparam logic [2:0] C_OP_INC = 3'b101;
    localparam logic [2:0] C_OP_DEC = 3'b110;
    localparam logic [2:0] C_OP_MUL = 3'b111;

    localparam logic [5:0] C_MUL_LAST = 6'(WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [2:0]         op_q,     op_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [5:0]         cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic               c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    // Single-cycle datapath: every arithmetic op is folded into A + y + cin
    logic [WIDTH-1:0]   w_y;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic               w_ovf;
    logic               w_logic;
    logic [WIDTH-1:0]   w_res;

    always_comb begin
        w_y     = b_q;
        w_cin   = 1'b0;
        w_logic = 1'b0;
        case (op_q)
            C_OP_SUB: begin w_y = ~b_q;        w_cin = 1'b1; end
            C_OP_INC: begin w_y = '0;          w_cin = 1'b1; end
            C_OP_DEC: begin w_y = '1;          w_cin = 1'b0; end
            default:  ;
        endcase
        w_sum = {1'b0, a_q} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
        // Signed overflow: operands agree in sign but the sum does not
        w_ovf = (a_q[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != a_q[WIDTH-1]);
        w_res = w_sum[WIDTH-1:0];
        case (op_q)
            C_OP_AND: begin w_res = a_q & b_q; w_logic = 1'b1; end
            C_OP_OR:  begin w_res = a_q | b_q; w_logic = 1'b1; end
            C_OP_XOR: begin w_res = a_q ^ b_q; w_logic = 1'b1; end
            default:  ;
        endcase
    end

    // Shift-add step: high half accumulates A when the multiplier LSB is set,
    // then the whole product register shifts right taking the carry along.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_step;

    always_comb begin
        w_mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        w_prod_step = {w_mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        c_d      = c_q;
        z_d      = z_q;
        v_d      = v_q;
        n_d      = n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                if (START) begin
                    a_d    = A;
                    b_d    = B;
                    op_d   = OP;
                    busy_d = 1'b1;
                    if (OP == C_OP_MUL) begin
                        state_d = C_ST_MUL;
                        prod_d  = {{WIDTH{1'b0}}, B};
                        cnt_d   = '0;
                    end else begin
                        state_d = C_ST_EXEC;
                    end
                end
            end
            C_ST_EXEC: begin
                result_d = w_res;
                hi_d     = '0;
                c_d      = w_logic ? 1'b0 : w_sum[WIDTH];
                v_d      = w_logic ? 1'b0 : w_ovf;
                z_d      = (w_res == '0);
                n_d      = w_res[WIDTH-1];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = C_ST_IDLE;
            end
            C_ST_MUL: begin
                prod_d = w_prod_step;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == C_MUL_LAST) begin
                    result_d = w_prod_step[WIDTH-1:0];
                    hi_d     = w_prod_step[2*WIDTH-1:WIDTH];
                    c_d      = |w_prod_step[2*WIDTH-1:WIDTH];
                    v_d      = 1'b0;
                    z_d      = (w_prod_step == '0);
                    n_d      = w_prod_step[2*WIDTH-1];
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q  <= C_ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            c_q      <= c_d;
            z_q      <= z_d;
            v_q      <= v_d;
            n_q      <= n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign RESULT    = result_q;
    assign RESULT_HI = hi_q;
    assign FLAG_C    = c_q;
    assign FLAG_Z    = z_q;
    assign FLAG_V    = v_q;
    assign FLAG_N    = n_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq (WIDTH=8) plus an
//            exhaustive WIDTH=4 sweep against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic       CLK;
    logic       CLR_N;
    logic       START;
    logic [2:0] OP;
    logic [7:0] A, B;
    logic [7:0] RESULT, RESULT_HI;
    logic       FLAG_C, FLAG_Z, FLAG_V, FLAG_N, BUSY, DONE;

    logic       START4;
    logic [2:0] OP4;
    logic [3:0] A4, B4;
    logic [3:0] RESULT4, RESULT_HI4;
    logic       FLAG_C4, FLAG_Z4, FLAG_V4, FLAG_N4, BUSY4, DONE4;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .START(START), .OP(OP), .A(A), .B(B),
        .RESULT(RESULT), .RESULT_HI(RESULT_HI),
        .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z), .FLAG_V(FLAG_V), .FLAG_N(FLAG_N),
        .BUSY(BUSY), .DONE(DONE)
    );

    alu_seq #(.WIDTH(4)) dut4 (
        .CLK(CLK), .CLR_N(CLR_N), .START(START4), .OP(OP4), .A(A4), .B(B4),
        .RESULT(RESULT4), .RESULT_HI(RESULT_HI4),
        .FLAG_C(FLAG_C4), .FLAG_Z(FLAG_Z4), .FLAG_V(FLAG_V4), .FLAG_N(FLAG_N4),
        .BUSY(BUSY4), .DONE(DONE4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present an op at the negedge, let the capture edge pass, drop START.
    task automatic start8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        START = 1'b1; OP = op; A = a; B = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Edges counted including the capture edge; -1 on timeout.
    task automatic wait_done8(output int edges);
        edges = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                edges = k + 2;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({RESULT, RESULT_HI, FLAG_C, FLAG_Z, FLAG_V, FLAG_N, BUSY, DONE} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h flags %b busy %b done %b, want all 0",
                     RESULT, RESULT_HI, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N}, BUSY, DONE);
        end
        @(negedge CLK);
        CLR_N = 1'b1;
    endtask

    task automatic test_add;
        int e;
        start8(3'b000, 8'h7F, 8'h01);
        wait_done8(e);
        checks++;
        if (e !== 2) begin
            errors++; $display("FAIL add_latency: got %0d edges, want 2", e);
        end
        checks++;
        if ({RESULT_HI, RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N} !== {8'h00, 8'h80, 4'b0011}) begin
            errors++;
            $display("FAIL add_7f_01: got hi %h res %h czvn %b, want 00 80 0011",
                     RESULT_HI, RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N});
        end
        start8(3'b000, 8'hFF, 8'h01);
        wait_done8(e);
        checks++;
        if ({RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N} !== {8'h00, 4'b1100}) begin
            errors++;
            $display("FAIL add_ff_01: got res %h czvn %b, want 00 1100",
                     RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N});
        end
    endtask

    task automatic test_sub;
        int e;
        start8(3'b001, 8'h05, 8'h05);
        wait_done8(e);
        checks++;
        if ({RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N} !== {8'h00, 4'b1100}) begin
            errors++;
            $display("FAIL sub_05_05: got res %h czvn %b, want 00 1100",
                     RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N});
        end
        start8(3'b001, 8'h03, 8'h05);
        wait_done8(e);
        checks++;
        if ({RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N} !== {8'hFE, 4'b0001}) begin
            errors++;
            $display("FAIL sub_03_05: got res %h czvn %b, want fe 0001",
                     RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N});
        end
    endtask

    // Outputs must hold, and DONE must fall, while inputs wiggle in IDLE.
    task automatic test_hold;
        A = 8'h55; B = 8'hAA; OP = 3'b000;
        @(posedge CLK);
        #1;
        checks++;
        if (DONE !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: got %b, want 0", DONE);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N, BUSY} !== {8'hFE, 5'b00010}) begin
            errors++;
            $display("FAIL hold: got res %h czvn %b busy %b, want fe 0001 0",
                     RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N}, BUSY);
        end
    endtask

    task automatic test_mul;
        int e = -1;
        int busy_cnt = 0;
        start8(3'b111, 8'hFF, 8'hFF);
        if (BUSY) busy_cnt++;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (BUSY) busy_cnt++;
            if (k == 2) begin START = 1'b1; OP = 3'b000; A = 8'h01; B = 8'h01; end
            if (k == 3) START = 1'b0;
            if (DONE) begin e = k + 2; break; end
        end
        checks++;
        if (e !== 9) begin
            errors++; $display("FAIL mul_latency: got %0d edges, want 9", e);
        end
        checks++;
        if (busy_cnt !== 8) begin
            errors++; $display("FAIL mul_busy: got %0d cycles, want 8", busy_cnt);
        end
        checks++;
        if ({RESULT_HI, RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N} !== {8'hFE, 8'h01, 4'b1001}) begin
            errors++;
            $display("FAIL mul_ff_ff: got hi %h res %h czvn %b, want fe 01 1001",
                     RESULT_HI, RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N});
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, RESULT} !== {2'b00, 8'h01}) begin
            errors++;
            $display("FAIL mul_start_ignored: got busy %b done %b res %h, want 0 0 01",
                     BUSY, DONE, RESULT);
        end
    endtask

    task automatic test_reset_mid_mul;
        int e;
        int seen = 0;
        start8(3'b111, 8'hFF, 8'hFF);
        repeat (2) @(posedge CLK);
        #1;
        CLR_N = 1'b0;
        #1;
        checks++;
        if ({RESULT, RESULT_HI, FLAG_C, FLAG_Z, FLAG_V, FLAG_N, BUSY, DONE} !== 22'd0) begin
            errors++;
            $display("FAIL reset_async: got %h/%h flags %b busy %b done %b, want all 0",
                     RESULT, RESULT_HI, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N}, BUSY, DONE);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        CLR_N = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL reset_abandon: got %0d busy/done cycles, want 0", seen);
        end
        start8(3'b000, 8'h02, 8'h03);
        wait_done8(e);
        checks++;
        if ({e, RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N} !== {32'sd2, 8'h05, 4'b0000}) begin
            errors++;
            $display("FAIL add_after_reset: got %0d edges res %h czvn %b, want 2 05 0000",
                     e, RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N});
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [7];
        logic [7:0] as  [7];
        logic [7:0] bs  [7];
        logic [7:0] rs  [7];
        logic [3:0] fs  [7];
        int idx = 0;
        int last = -1;
        ops[0] = 3'b000; as[0] = 8'h01; bs[0] = 8'h02; rs[0] = 8'h03; fs[0] = 4'b0000;
        ops[1] = 3'b001; as[1] = 8'h09; bs[1] = 8'h04; rs[1] = 8'h05; fs[1] = 4'b1000;
        ops[2] = 3'b100; as[2] = 8'hF0; bs[2] = 8'hFF; rs[2] = 8'h0F; fs[2] = 4'b0000;
        ops[3] = 3'b011; as[3] = 8'h10; bs[3] = 8'h01; rs[3] = 8'h11; fs[3] = 4'b0000;
        ops[4] = 3'b010; as[4] = 8'h3C; bs[4] = 8'h0F; rs[4] = 8'h0C; fs[4] = 4'b0000;
        ops[5] = 3'b101; as[5] = 8'h7F; bs[5] = 8'h33; rs[5] = 8'h80; fs[5] = 4'b0011;
        ops[6] = 3'b110; as[6] = 8'h00; bs[6] = 8'h33; rs[6] = 8'hFF; fs[6] = 4'b0001;
        @(negedge CLK);
        START = 1'b1; OP = ops[0]; A = as[0]; B = bs[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                checks++;
                if ({cyc - last, RESULT, FLAG_C, FLAG_Z, FLAG_V, FLAG_N} !== {32'sd2, rs[idx], fs[idx]}) begin
                    errors++;
                    $display("FAIL b2b_op%0d: got gap %0d res %h czvn %b, want 2 %h %b",
                             idx, cyc - last, RESULT, {FLAG_C, FLAG_Z, FLAG_V, FLAG_N}, rs[idx], fs[idx]);
                end
                last = cyc;
                idx++;
                if (idx == 7) break;
                OP = ops[idx]; A = as[idx]; B = bs[idx];
            end
        end
        START = 1'b0;
        checks++;
        if (idx !== 7) begin
            errors++; $display("FAIL b2b_count: got %0d completions, want 7", idx);
        end
    endtask

    function automatic logic [11:0] model4(input int op, input int a, input int b);
        int sa, sb, r, s, p;
        logic c, v, z, n;
        logic [3:0] res, hi;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        r = 0; s = 0; p = 0; c = 1'b0; v = 1'b0; hi = 4'h0;
        case (op)
            0: begin r = a + b; c = (r > 15);  s = sa + sb; v = (s > 7) || (s < -8); end
            1: begin r = a - b; c = (a >= b);  s = sa - sb; v = (s > 7) || (s < -8); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a + 1; c = (a == 15); s = sa + 1;  v = (s > 7); end
            6: begin r = a - 1; c = (a != 0);  s = sa - 1;  v = (s < -8); end
            default: begin p = a * b; r = p; hi = p[7:4]; c = (hi != 4'h0); end
        endcase
        res = r[3:0];
        z = (op == 7) ? (p == 0) : (res == 4'h0);
        n = (op == 7) ? hi[3] : res[3];
        return {hi, res, c, z, v, n};
    endfunction

    task automatic test_exhaustive4;
        logic [11:0] exp;
        int bad = 0;
        for (int op = 0; op < 8; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    bit got = 1'b0;
                    @(negedge CLK);
                    START4 = 1'b1; OP4 = op[2:0]; A4 = a[3:0]; B4 = b[3:0];
                    @(posedge CLK);
                    #1;
                    START4 = 1'b0;
                    for (int k = 0; k < 12; k++) begin
                        @(posedge CLK);
                        #1;
                        if (DONE4) begin got = 1'b1; break; end
                    end
                    exp = model4(op, a, b);
                    checks++;
                    if (!got || {RESULT_HI4, RESULT4, FLAG_C4, FLAG_Z4, FLAG_V4, FLAG_N4} !== exp) begin
                        errors++;
                        bad++;
                        $display("FAIL w4 op%0d a%0d b%0d: got done %b hi %h res %h czvn %b, want hi %h res %h czvn %b",
                                 op, a, b, got, RESULT_HI4, RESULT4,
                                 {FLAG_C4, FLAG_Z4, FLAG_V4, FLAG_N4}, exp[11:8], exp[7:4], exp[3:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        CLR_N = 1'b0; START = 1'b0; OP = 3'b000; A = 8'h00; B = 8'h00;
        START4 = 1'b0; OP4 = 3'b000; A4 = 4'h0; B4 = 4'h0;
        test_reset;
        test_add;
        test_sub;
        test_hold;
        test_mul;
        test_reset_mid_mul;
        test_back_to_back;
        test_exhaustive4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
